biquad_mac_seq: RTL and testbench

- Time-multiplexed direct-form-I biquad controller that drives a single shared unsigned magnitude multiplier (`multb`-style, width-1 operands) through the five filter products per sample.
- Accumulates the five products into one result.
- Converts operands between two's-complement and sign-magnitude.
- Owns the x/y delay line and produces one filtered output per accepted input sample.

---
 rtl/biquad_mac_seq_pkg.sv | 27 ++
 rtl/biquad_mac_seq_if.sv | 24 ++
 rtl/biquad_sm_split.sv | 20 ++
 rtl/biquad_mac_seq.sv | 178 +++++++++++++++++
 tb/tb_biquad_mac_seq.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/biquad_mac_seq_pkg.sv
// Shared types and constants for the biquad_mac_seq slice (package biquad_pkg).
// Width-dependent constants here reflect the default 16-bit configuration.
package biquad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_DONE
    } state_e;

    localparam int unsigned NUM_TAPS = 5;

    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;

    localparam int DEF_DATAWIDTH = 16;
    localparam int DEF_COEFWIDTH = 16;

    localparam int FRAC_SHIFT = DEF_COEFWIDTH - 2;

    localparam longint SAT_MAX = (longint'(1) <<< (DEF_DATAWIDTH - 1)) - 1;
    localparam longint SAT_MIN = -(longint'(1) <<< (DEF_DATAWIDTH - 1));

endpackage

// File: rtl/biquad_mac_seq_if.sv
// Sample stream and shared-multiplier bus of biquad_mac_seq.
interface biquad_mac_seq_if #(
    parameter int DATAWIDTH = 16,
    parameter int COEFWIDTH = 16
);
    logic [DATAWIDTH-1:0]           din;
    logic                           din_valid;
    logic                           din_ready;
    logic [DATAWIDTH-1:0]           dout;
    logic                           dout_valid;
    logic [COEFWIDTH-2:0]           mult_a;
    logic [DATAWIDTH-2:0]           mult_b;
    logic [DATAWIDTH+COEFWIDTH-3:0] mult_p;

    modport slave (
        input  din, din_valid, mult_p,
        output din_ready, dout, dout_valid, mult_a, mult_b
    );

    modport master (
        output din, din_valid, mult_p,
        input  din_ready, dout, dout_valid, mult_a, mult_b
    );
endinterface

// File: rtl/biquad_sm_split.sv
// Two's complement to sign + magnitude; the most negative value clamps to the
// largest W-1 bit magnitude so it fits the multiplier operand.
module biquad_sm_split #(
    parameter int W = 16
) (
    input  logic [W-1:0] v,
    output logic         sign,
    output logic [W-2:0] mag
);
    logic [W-1:0] neg;

    always_comb begin
        neg  = '0 - v;
        sign = v[W-1];
        mag  = v[W-2:0];
        if (v[W-1]) begin
            mag = neg[W-1] ? '1 : neg[W-2:0];
        end
    end
endmodule

// File: rtl/biquad_mac_seq.sv
// Time-multiplexed DF-I biquad: five products per sample through one shared multiplier.
// Define BIQUAD_MAC_SEQ_SAT_EN to saturate the output narrowing instead of wrapping.
module biquad_mac_seq
    import biquad_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int COEFWIDTH = DEF_COEFWIDTH,
    parameter int ACCWIDTH  = DATAWIDTH + COEFWIDTH + 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [COEFWIDTH-1:0] b0,
    input  logic [COEFWIDTH-1:0] b1,
    input  logic [COEFWIDTH-1:0] b2,
    input  logic [COEFWIDTH-1:0] a1,
    input  logic [COEFWIDTH-1:0] a2,
    biquad_mac_seq_if.slave      bus
);
    localparam int FRAC = COEFWIDTH - 2;
    localparam int PW   = DATAWIDTH + COEFWIDTH - 2;

    state_e                     state_q, state_d;
    logic [2:0]                 tap_q, tap_d;
    logic signed [ACCWIDTH-1:0] acc_q, acc_d;
    logic [DATAWIDTH-1:0]       x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
    logic [DATAWIDTH-1:0]       y1_q, y1_d, y2_q, y2_d;
    logic [DATAWIDTH-1:0]       dout_q, dout_d;
    logic                       dout_valid_q, dout_valid_d;
    logic [COEFWIDTH-1:0]       coef_q [NUM_TAPS];
    logic [COEFWIDTH-1:0]       coef_d [NUM_TAPS];

    logic [COEFWIDTH-1:0]       coef_sel;
    logic [DATAWIDTH-1:0]       data_sel;
    logic                       c_sign, d_sign, prod_neg;
    logic [COEFWIDTH-2:0]       c_mag;
    logic [DATAWIDTH-2:0]       d_mag;
    logic signed [ACCWIDTH-1:0] prod_ext, prod_signed;
    logic [DATAWIDTH-1:0]       y;

    always_comb begin
        case (tap_q)
            TAP_B0:  begin coef_sel = coef_q[0]; data_sel = x0_q; end
            TAP_B1:  begin coef_sel = coef_q[1]; data_sel = x1_q; end
            TAP_B2:  begin coef_sel = coef_q[2]; data_sel = x2_q; end
            TAP_A1:  begin coef_sel = coef_q[3]; data_sel = y1_q; end
            default: begin coef_sel = coef_q[4]; data_sel = y2_q; end
        endcase
    end

    biquad_sm_split #(.W(COEFWIDTH)) u_coef_split (
        .v    (coef_sel),
        .sign (c_sign),
        .mag  (c_mag)
    );

    biquad_sm_split #(.W(DATAWIDTH)) u_data_split (
        .v    (data_sel),
        .sign (d_sign),
        .mag  (d_mag)
    );

    // Feedback taps subtract, so their product sign is flipped.
    always_comb begin
        prod_neg    = c_sign ^ d_sign ^ (tap_q >= TAP_A1);
        prod_ext    = {{(ACCWIDTH - PW){1'b0}}, bus.mult_p};
        prod_signed = prod_neg ? ('0 - prod_ext) : prod_ext;
    end

`ifdef BIQUAD_MAC_SEQ_SAT_EN
    localparam logic signed [ACCWIDTH-1:0] Y_MAX =
        {{(ACCWIDTH - DATAWIDTH + 1){1'b0}}, {(DATAWIDTH - 1){1'b1}}};
    localparam logic signed [ACCWIDTH-1:0] Y_MIN =
        {{(ACCWIDTH - DATAWIDTH + 1){1'b1}}, {(DATAWIDTH - 1){1'b0}}};
    logic signed [ACCWIDTH-1:0] acc_shift;

    always_comb begin
        acc_shift = acc_q >>> FRAC;
        y         = acc_shift[DATAWIDTH-1:0];
        if (acc_shift > Y_MAX) begin
            y = {1'b0, {(DATAWIDTH - 1){1'b1}}};
        end else if (acc_shift < Y_MIN) begin
            y = {1'b1, {(DATAWIDTH - 1){1'b0}}};
        end
    end
`else
    // Arithmetic shift then wrap only needs the window above the fraction bits.
    always_comb begin
        y = acc_q[FRAC +: DATAWIDTH];
    end
`endif

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        acc_d        = acc_q;
        x0_d         = x0_q;
        x1_d         = x1_q;
        x2_d         = x2_q;
        y1_d         = y1_q;
        y2_d         = y2_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        coef_d       = coef_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.din_valid) begin
                    x0_d      = bus.din;
                    coef_d[0] = b0;
                    coef_d[1] = b1;
                    coef_d[2] = b2;
                    coef_d[3] = a1;
                    coef_d[4] = a2;
                    acc_d     = '0;
                    tap_d     = TAP_B0;
                    state_d   = ST_MAC;
                end else if (clear) begin
                    x1_d = '0;
                    x2_d = '0;
                    y1_d = '0;
                    y2_d = '0;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + prod_signed;
                if (tap_q == TAP_A2) begin
                    state_d = ST_DONE;
                end else begin
                    tap_d = 3'(tap_q + 3'd1);
                end
            end
            ST_DONE: begin
                dout_d       = y;
                y2_d         = y1_q;
                y1_d         = y;
                x2_d         = x1_q;
                x1_d         = x0_q;
                dout_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            acc_q        <= '0;
            x0_q         <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            y1_q         <= '0;
            y2_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            coef_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            acc_q        <= acc_d;
            x0_q         <= x0_d;
            x1_q         <= x1_d;
            x2_q         <= x2_d;
            y1_q         <= y1_d;
            y2_q         <= y2_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            coef_q       <= coef_d;
        end
    end

    assign bus.din_ready  = (state_q == ST_IDLE);
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.mult_a     = (state_q == ST_MAC) ? c_mag : '0;
    assign bus.mult_b     = (state_q == ST_MAC) ? d_mag : '0;
endmodule

// File: tb/tb_biquad_mac_seq.sv
// Self-checking bench for biquad_mac_seq: directed cases plus randomized samples
// against an arithmetic difference-equation model. Honours BIQUAD_MAC_SEQ_SAT_EN.
module tb_biquad_mac_seq;
    import biquad_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               clear;
    logic signed [15:0] b0, b1, b2, a1, a2;

    biquad_mac_seq_if #(.DATAWIDTH(16), .COEFWIDTH(16)) bus ();

    biquad_mac_seq #(.DATAWIDTH(16), .COEFWIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .b0    (b0),
        .b1    (b1),
        .b2    (b2),
        .a1    (a1),
        .a2    (a2),
        .bus   (bus)
    );

    // Ideal unsigned multiplier shared with the DUT.
    assign bus.mult_p = 30'(bus.mult_a) * 30'(bus.mult_b);

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint mx1, mx2, my1, my2;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint smv(input longint v);
        return (v == SAT_MIN) ? SAT_MIN + 1 : v;
    endfunction

    task automatic model_clear();
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    endtask

    // y[n] = (b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2) / 2^14, floored, then narrowed
    task automatic model_step(input longint x, output longint y);
        longint             acc, s;
        logic signed [15:0] t;
        acc = smv(b0) * smv(x) + smv(b1) * smv(mx1) + smv(b2) * smv(mx2)
            - smv(a1) * smv(my1) - smv(a2) * smv(my2);
        s = acc >>> FRAC_SHIFT;
`ifdef BIQUAD_MAC_SEQ_SAT_EN
        y = (s > SAT_MAX) ? SAT_MAX : (s < SAT_MIN) ? SAT_MIN : s;
`else
        t = 16'(s);
        y = t;
`endif
        mx2 = mx1; mx1 = x;
        my2 = my1; my1 = y;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
    endtask

    // Offer one sample, wait for its result; lat counts edges after the accepting edge.
    task automatic run_sample(input longint x, input logic with_clear,
                              output longint y, output longint exp,
                              output int lat, output int low);
        int n = 0;
        while (!bus.din_ready && n < 20) begin
            tick();
            n++;
        end
        bus.din       = 16'(x);
        bus.din_valid = 1'b1;
        clear         = with_clear;
        tick();
        bus.din_valid = 1'b0;
        clear         = 1'b0;
        lat = 0;
        low = 0;
        while (!bus.dout_valid && lat < 20) begin
            if (!bus.din_ready) low++;
            tick();
            lat++;
        end
        y = longint'($signed(bus.dout));
        model_step(x, exp);
    endtask

    task automatic directed(input string tag, input longint x, input longint want);
        longint y, exp;
        int     lat, low;
        run_sample(x, 1'b0, y, exp, lat, low);
        check(tag, y, want);
        check({tag, "_lat"}, longint'(lat), 6);
    endtask

    initial begin
        longint y, exp;
        int     lat, low, accepts, outs, vcount;
        reset = 1'b1; clear = 1'b0;
        bus.din = '0; bus.din_valid = 1'b0;
        b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
        model_clear();
        repeat (3) tick();
        reset = 1'b0;

        check("rst_dout", longint'(bus.dout), 0);
        check("rst_valid", longint'(bus.dout_valid), 0);
        check("rst_ready", longint'(bus.din_ready), 1);
        check("rst_mult_a", longint'(bus.mult_a), 0);
        check("rst_mult_b", longint'(bus.mult_b), 0);

        // Pass-through with timing: 6 busy cycles, result arrives as ready returns.
        b0 = 16384;
        run_sample(1000, 1'b0, y, exp, lat, low);
        check("pass_y", y, 1000);
        check("pass_lat", longint'(lat), 6);
        check("pass_busy", longint'(low), 6);
        check("pass_ready", longint'(bus.din_ready), 1);
        tick();
        check("pass_pulse", longint'(bus.dout_valid), 0);
        check("pass_hold", longint'($signed(bus.dout)), 1000);

        do_clear();
        b0 = 0; b1 = 16384;
        directed("delay0", 100, 0);
        directed("delay1", 200, 100);
        directed("delay2", 300, 200);

        do_clear();
        b1 = 0; b0 = 16384; a1 = -8192;
        directed("fb0", 4096, 4096);
        directed("fb1", 0, 2048);
        directed("fb2", 0, 1024);

        do_clear();
        directed("clr0", 4096, 4096);
        directed("clr1", 0, 2048);

        do_clear();
        a1 = 0;
        directed("negfs", -32768, -32767);

        do_clear();
        b0 = 32767;
`ifdef BIQUAD_MAC_SEQ_SAT_EN
        directed("ovf", 30000, 32767);
`else
        directed("ovf", 30000, -5538);
`endif

        // din_valid held high across three sample periods.
        do_clear();
        b0 = 16384;
        bus.din = 16'(500);
        bus.din_valid = 1'b1;
        accepts = 0;
        outs = 0;
        for (int i = 0; i < 21; i++) begin
            if (bus.din_ready && bus.din_valid) accepts++;
            tick();
            if (bus.dout_valid) begin
                outs++;
                check("hold_y", longint'($signed(bus.dout)), 500);
            end
        end
        bus.din_valid = 1'b0;
        check("hold_accepts", longint'(accepts), 3);
        check("hold_outs", longint'(outs), 3);
        for (int i = 0; i < 3; i++) model_step(500, exp);

        // Reset while tap 2 is in flight.
        a1 = -8192;
        bus.din = 16'(1234);
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.dout_valid) vcount++;
            tick();
        end
        check("mrst_novalid", longint'(vcount), 0);
        check("mrst_dout", longint'(bus.dout), 0);
        check("mrst_ready", longint'(bus.din_ready), 1);
        directed("mrst_next0", 4096, 4096);
        directed("mrst_next1", 0, 2048);

        // Randomized coefficients, samples, clears, and clear colliding with a sample.
        do_clear();
        for (int i = 0; i < 60; i++) begin
            longint x;
            logic   clr_with;
            if (i % 8 == 0) begin
                b0 = 16'($urandom);
                b1 = 16'($urandom);
                b2 = 16'($urandom);
                a1 = 16'($urandom_range(0, 3) == 0 ? 32'h8000 : $urandom);
                a2 = 16'($urandom_range(0, 16383));
            end
            if ($urandom_range(0, 5) == 0) do_clear();
            x = ($urandom_range(0, 7) == 0) ? SAT_MIN
                                            : longint'($signed(16'($urandom)));
            clr_with = ($urandom_range(0, 4) == 0);
            run_sample(x, clr_with, y, exp, lat, low);
            check("rand_y", y, exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
